onchip_mem_arbiter: RTL and testbench

Two-master arbiter and command sequencer in front of the 8192 x 32-bit single-port on-chip RAM. It grants one Avalon-MM request per cycle, registers it, and drives it onto the RAM port one cycle later. It routes each read result back to the master that issued it with `readdatavalid`. It sits between the CPU data master / DMA master and the RAM slave in the system interconnect.

---
 rtl/onchip_mem_arbiter_pkg.sv | 22 ++
 rtl/onchip_mem_arbiter_if.sv | 51 +++++
 rtl/onchip_mem_arbiter_grant.sv | 38 +++
 rtl/onchip_mem_arbiter.sv | 107 ++++++++++
 tb/tb_onchip_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared types and constants for the on-chip RAM arbiter.
package onchip_mem_pkg;

    localparam int unsigned ONCHIP_ADDR_W = 13;
    localparam int unsigned ONCHIP_DATA_W = 32;
    localparam int unsigned ONCHIP_BE_W   = 4;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

    // Accepted command as held in the command stage
    typedef struct packed {
        master_id_e                master;
        logic                      write;
        logic [ONCHIP_ADDR_W-1:0]  address;
        logic [ONCHIP_BE_W-1:0]    byteenable;
        logic [ONCHIP_DATA_W-1:0]  writedata;
    } onchip_cmd_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM master-side bus and RAM-side bus used by the arbiter.
interface onchip_mem_arbiter_if
    import onchip_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ONCHIP_ADDR_W,
    parameter int unsigned DATA_W = ONCHIP_DATA_W
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

interface onchip_ram_if
    import onchip_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ONCHIP_ADDR_W,
    parameter int unsigned DATA_W = ONCHIP_DATA_W
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                clken;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, byteenable, chipselect, write, writedata, clken,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, clken,
        output readdata
    );
endinterface

// File: rtl/onchip_mem_arbiter_grant.sv
// Combinational one-hot grant for two masters.
// Build option: ONCHIP_ARB_ROUND_ROBIN_EN selects round-robin; default is fixed priority (M0 first).
module onchip_arb_grant
    import onchip_mem_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_e last_grant,
    input  logic       freeze,
    input  logic       reset,
    output logic [1:0] grant
);

`ifndef ONCHIP_ARB_ROUND_ROBIN_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick at most one requester; nothing is granted while frozen or in reset
    always_comb begin
        grant = 2'b00;
        if (!reset && !freeze) begin
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
            if (req == 2'b11) begin
                grant = (last_grant == M0) ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
`else
            if (req[0]) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end
`endif
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter and command sequencer for the single-port on-chip RAM.
// Build option: ONCHIP_ARB_ROUND_ROBIN_EN (see onchip_arb_grant).
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ONCHIP_ADDR_W,
    parameter int unsigned DATA_W = ONCHIP_DATA_W
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 freeze,
    onchip_mem_arbiter_if.slave  m0,
    onchip_mem_arbiter_if.slave  m1,
    onchip_ram_if.master         mem
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              any_grant;
    master_id_e        sel_master;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;

    onchip_cmd_t       cmd;
    logic              cmd_valid;
    logic              rd_valid;
    master_id_e        rd_master;
    master_id_e        last_grant;

    assign req[0] = m0.read | m0.write;
    assign req[1] = m1.read | m1.write;

    onchip_arb_grant u_grant (
        .req        (req),
        .last_grant (last_grant),
        .freeze     (freeze),
        .reset      (reset),
        .grant      (grant)
    );

    assign any_grant = |grant;

    // Mux the granted master's request; a write flag wins over read
    always_comb begin
        sel_master = grant[1] ? M1 : M0;
        sel_write  = grant[1] ? m1.write      : m0.write;
        sel_addr   = grant[1] ? m1.address    : m0.address;
        sel_be     = grant[1] ? m1.byteenable : m0.byteenable;
        sel_wdata  = grant[1] ? m1.writedata  : m0.writedata;
    end

    // Command stage, return stage and arbitration history
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            rd_valid   <= 1'b0;
            rd_master  <= M0;
            last_grant <= M1;
        end else begin
            cmd_valid <= any_grant;
            if (any_grant) begin
                cmd.master     <= sel_master;
                cmd.write      <= sel_write;
                cmd.address    <= ONCHIP_ADDR_W'(sel_addr);
                cmd.byteenable <= ONCHIP_BE_W'(sel_be);
                cmd.writedata  <= ONCHIP_DATA_W'(sel_wdata);
                last_grant     <= sel_master;
            end
            rd_valid  <= cmd_valid & ~cmd.write;
            rd_master <= cmd.master;
        end
    end

    // Master-side handshake and read return
    always_comb begin
        m0.waitrequest   = ~grant[0];
        m1.waitrequest   = ~grant[1];
        m0.readdata      = mem.readdata;
        m1.readdata      = mem.readdata;
        m0.readdatavalid = rd_valid & (rd_master == M0);
        m1.readdatavalid = rd_valid & (rd_master == M1);
    end

    // RAM port driven from the command registers
    always_comb begin
        mem.chipselect = cmd_valid;
        mem.write      = cmd_valid & cmd.write;
        mem.address    = ADDR_W'(cmd.address);
        mem.byteenable = BE_W'(cmd.byteenable);
        mem.writedata  = DATA_W'(cmd.writedata);
        mem.clken      = ~reset;
    end

    // Flag simultaneous read and write; such requests execute as writes
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(m0.read && m0.write)) else $error("m0 asserted read and write together");
            assert (!(m1.read && m1.write)) else $error("m1 asserted read and write together");
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural RAM.
module tb_onchip_mem_arbiter;
    import onchip_mem_pkg::*;

    logic clk;
    logic reset;
    logic freeze;
    logic ram_init;
    int   total;
    int   bad;

    onchip_mem_arbiter_if m0_if ();
    onchip_mem_arbiter_if m1_if ();
    onchip_ram_if         mem_if ();

    onchip_mem_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .freeze (freeze),
        .m0     (m0_if),
        .m1     (m1_if),
        .mem    (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8192x32 RAM with one-cycle registered read
    logic [31:0] ram [0:8191];

    function automatic logic [31:0] init_val(input int a);
        if (a == 5)         return 32'hDEAD_BEEF;
        else if (a == 'h40) return 32'hFFFF_FFFF;
        else                return 32'hA000_0000 + 32'(a);
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int a = 0; a < 8192; a++) ram[a] <= init_val(a);
        end else if (mem_if.clken && mem_if.chipselect) begin
            if (mem_if.write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_if.byteenable[b]) ram[mem_if.address][8*b +: 8] <= mem_if.writedata[8*b +: 8];
                end
            end else begin
                mem_if.readdata <= ram[mem_if.address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_masters();
        m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.address = '0;
        m0_if.byteenable = 4'hF; m0_if.writedata = '0;
        m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = '0;
        m1_if.byteenable = 4'hF; m1_if.writedata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr0"}, 32'(m0_if.waitrequest), 32'd1);
        chk({tag, "_wr1"}, 32'(m1_if.waitrequest), 32'd1);
        chk({tag, "_cs"},  32'(mem_if.chipselect), 32'd0);
        chk({tag, "_we"},  32'(mem_if.write), 32'd0);
        chk({tag, "_rdv0"}, 32'(m0_if.readdatavalid), 32'd0);
        chk({tag, "_rdv1"}, 32'(m1_if.readdatavalid), 32'd0);
        chk({tag, "_addr"}, 32'(mem_if.address), 32'd0);
        chk({tag, "_be"},   32'(mem_if.byteenable), 32'd0);
        chk({tag, "_wdata"}, mem_if.writedata, 32'd0);
    endtask

    // Expected grant per cycle in the contention run (2 = no grant)
    int exp_g [0:7];
    int gaddr [0:7];
    int n0;
    int n1;

    initial begin
        total = 0;
        bad = 0;
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1, 0, 1, 2, 2};
`else
        exp_g = '{0, 0, 0, 1, 1, 1, 2, 2};
`endif
        reset = 1'b1;
        freeze = 1'b0;
        ram_init = 1'b1;
        idle_masters();

        // Reset state
        step();
        ram_init = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst");
        chk("rst_clken", 32'(mem_if.clken), 32'd0);

        // Single read from m0
        step();
        reset = 1'b0;
        m0_if.read = 1'b1;
        m0_if.address = 13'h0005;
        @(negedge clk);
        chk("rd_wr0", 32'(m0_if.waitrequest), 32'd0);
        chk("rd_clken", 32'(mem_if.clken), 32'd1);
        step();
        idle_masters();
        @(negedge clk);
        chk("rd_cs", 32'(mem_if.chipselect), 32'd1);
        chk("rd_addr", 32'(mem_if.address), 32'h5);
        chk("rd_we", 32'(mem_if.write), 32'd0);
        chk("rd_rdv0_early", 32'(m0_if.readdatavalid), 32'd0);
        step();
        @(negedge clk);
        chk("rd_rdv0", 32'(m0_if.readdatavalid), 32'd1);
        chk("rd_data", m0_if.readdata, 32'hDEAD_BEEF);
        chk("rd_rdv1", 32'(m1_if.readdatavalid), 32'd0);

        // Fresh reset so contention starts from last_grant = M1
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Contention: each master issues three reads
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 8; c++) begin
            m0_if.read = (n0 < 3);
            m0_if.address = 13'(16'h10 + n0);
            m1_if.read = (n1 < 3);
            m1_if.address = 13'(16'h20 + n1);
            @(negedge clk);
            chk($sformatf("ct_wr0_c%0d", c), 32'(m0_if.waitrequest), (exp_g[c] == 0) ? 32'd0 : 32'd1);
            chk($sformatf("ct_wr1_c%0d", c), 32'(m1_if.waitrequest), (exp_g[c] == 1) ? 32'd0 : 32'd1);
            chk($sformatf("ct_cs_c%0d", c), 32'(mem_if.chipselect), (c >= 1 && c <= 6) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                chk($sformatf("ct_rdv0_c%0d", c), 32'(m0_if.readdatavalid), (exp_g[c-2] == 0) ? 32'd1 : 32'd0);
                chk($sformatf("ct_rdv1_c%0d", c), 32'(m1_if.readdatavalid), (exp_g[c-2] == 1) ? 32'd1 : 32'd0);
                if (exp_g[c-2] != 2) begin
                    chk($sformatf("ct_data_c%0d", c), mem_if.readdata, 32'hA000_0000 + 32'(gaddr[c-2]));
                end
            end
            if (exp_g[c] == 0) begin
                gaddr[c] = 'h10 + n0;
                n0++;
            end else if (exp_g[c] == 1) begin
                gaddr[c] = 'h20 + n1;
                n1++;
            end else begin
                gaddr[c] = 0;
            end
            step();
        end
        idle_masters();

        // Byte-lane write from m1, then read back
        m1_if.write = 1'b1;
        m1_if.address = 13'h0040;
        m1_if.writedata = 32'h1122_3344;
        m1_if.byteenable = 4'b0101;
        @(negedge clk);
        chk("bw_wr1", 32'(m1_if.waitrequest), 32'd0);
        step();
        m1_if.write = 1'b0;
        m1_if.read = 1'b1;
        @(negedge clk);
        chk("bw_wr1_rd", 32'(m1_if.waitrequest), 32'd0);
        chk("bw_cs", 32'(mem_if.chipselect), 32'd1);
        chk("bw_we", 32'(mem_if.write), 32'd1);
        chk("bw_be", 32'(mem_if.byteenable), 32'h5);
        chk("bw_wdata", mem_if.writedata, 32'h1122_3344);
        step();
        idle_masters();
        @(negedge clk);
        chk("bw_rd_cs", 32'(mem_if.chipselect), 32'd1);
        chk("bw_rd_we", 32'(mem_if.write), 32'd0);
        step();
        @(negedge clk);
        chk("bw_rdv1", 32'(m1_if.readdatavalid), 32'd1);
        chk("bw_data", m1_if.readdata, 32'hFF22_FF44);
        chk("bw_rdv0", 32'(m0_if.readdatavalid), 32'd0);

        // Freeze with both masters requesting
        step();
        m0_if.read = 1'b1;
        m0_if.address = 13'h0005;
        m1_if.read = 1'b1;
        m1_if.address = 13'h0010;
        @(negedge clk);
        chk("fz_pre_wr0", 32'(m0_if.waitrequest), 32'd0);
        step();
        freeze = 1'b1;
        @(negedge clk);
        chk("fz_wr0", 32'(m0_if.waitrequest), 32'd1);
        chk("fz_wr1", 32'(m1_if.waitrequest), 32'd1);
        chk("fz_cs_drain", 32'(mem_if.chipselect), 32'd1);
        step();
        @(negedge clk);
        chk("fz_cs_off", 32'(mem_if.chipselect), 32'd0);
        chk("fz_wr0_b", 32'(m0_if.waitrequest), 32'd1);
        chk("fz_wr1_b", 32'(m1_if.waitrequest), 32'd1);
        chk("fz_rdv0", 32'(m0_if.readdatavalid), 32'd1);
        chk("fz_data", m0_if.readdata, 32'hDEAD_BEEF);
        step();
        @(negedge clk);
        chk("fz_cs_off2", 32'(mem_if.chipselect), 32'd0);
        chk("fz_rdv0_off", 32'(m0_if.readdatavalid), 32'd0);

        // Read followed by reset on the next cycle
        step();
        freeze = 1'b0;
        idle_masters();
        m0_if.read = 1'b1;
        m0_if.address = 13'h0011;
        @(negedge clk);
        chk("mr_wr0", 32'(m0_if.waitrequest), 32'd0);
        step();
        idle_masters();
        reset = 1'b1;
        @(negedge clk);
        chk("mr_clken", 32'(mem_if.clken), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mr");
        chk("mr_clken_on", 32'(mem_if.clken), 32'd1);
        step();
        @(negedge clk);
        chk("mr_rdv0_late", 32'(m0_if.readdatavalid), 32'd0);
        chk("mr_rdv1_late", 32'(m1_if.readdatavalid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
